// File: rtl/gaussian_filter_stream_if.sv
// Column-in / pixel-out stream bundle for the Gaussian filter.
// The slave view is the filter; the master view is the surrounding pipeline.
interface gaussian_filter_stream_if #(
    parameter int PW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [5*PW-1:0] in_col;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   pixel_out;
    logic            out_last;

    modport slave (
        input  in_valid, in_col, in_last, out_ready,
        output in_ready, out_valid, pixel_out, out_last
    );

    modport master (
        output in_valid, in_col, in_last, out_ready,
        input  in_ready, out_valid, pixel_out, out_last
    );
endinterface

// File: rtl/gaussian_filter_stream.sv
// Streaming 5x5 / 3x3 Gaussian smoother over a sliding column window, strip by strip,
// with valid/ready on both sides and start/last/done frame control.
module gaussian_filter_stream #(
    parameter int PW      = 5,
    parameter int STRIP_W = 64,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    gaussian_filter_stream_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       out_count
);
    localparam int CW  = $clog2(STRIP_W + 1);
    localparam int SW5 = PW + 8;
    localparam int SW3 = PW + 4;
    localparam int SCW = PW + 15;

    localparam logic [3:0] K5 [5][5] = '{
        '{4'd2, 4'd4,  4'd5,  4'd4,  4'd2},
        '{4'd4, 4'd9,  4'd12, 4'd9,  4'd4},
        '{4'd5, 4'd12, 4'd15, 4'd12, 4'd5},
        '{4'd4, 4'd9,  4'd12, 4'd9,  4'd4},
        '{4'd2, 4'd4,  4'd5,  4'd4,  4'd2}
    };
    localparam logic [2:0] K3 [3][3] = '{
        '{3'd1, 3'd2, 3'd1},
        '{3'd2, 3'd4, 3'd2},
        '{3'd1, 3'd2, 3'd1}
    };

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_DONE} state_e;
    typedef logic [5*PW-1:0] col_t;

    state_e           state_q, state_d;
    col_t             win_q [5];
    col_t             win_d [5];
    logic [CW-1:0]    col_cnt_q, col_cnt_d, cnt_inc;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    pixel_q, pixel_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             in_ready, accept, out_hs, full, wrap;
    logic [SW5-1:0]   sum5;
    logic [SW3-1:0]   sum3, rnd3;
    logic [SCW-1:0]   scaled;
    logic [PW:0]      q5, q3, qsel;
    logic [PW-1:0]    filt;

    assign in_ready = (state_q == ST_FILL || state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;
    assign cnt_inc  = col_cnt_q + CW'(1);
    assign full     = cnt_inc >= CW'(5);
    assign wrap     = cnt_inc == CW'(STRIP_W);

    // Post-shift window: the filter always sees the window as it will be after this accept.
    always_comb begin
        for (int i = 0; i < 4; i++) win_d[i] = win_q[i+1];
        win_d[4] = bus.in_col;
    end

    always_comb begin
        sum5 = '0;
        sum3 = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                sum5 = sum5 + SW5'(K5[r][c]) * SW5'(win_d[c][r*PW +: PW]);
        for (int r = 1; r < 4; r++)
            for (int c = 1; c < 4; c++)
                sum3 = sum3 + SW3'(K3[r-1][c-1]) * SW3'(win_d[c][r*PW +: PW]);
        // 103/2^14 approximates 1/159; the +8192 rounds to nearest.
        scaled = SCW'(sum5) * SCW'(103) + SCW'(8192);
        q5     = scaled[SCW-1:14];
        rnd3   = sum3 + SW3'(8);
        q3     = {1'b0, rnd3[SW3-1:4]};
        qsel   = mode_q ? q3 : q5;
        filt   = (qsel > {1'b0, {PW{1'b1}}}) ? {PW{1'b1}} : qsel[PW-1:0];
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        pixel_d     = pixel_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        out_count_d = out_count_q + CNT_W'(out_hs);

        if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) done_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    col_cnt_d   = '0;
                    mode_d      = mode;
                    out_count_d = '0;
                end
            end
            ST_FILL, ST_RUN: begin
                if (accept) begin
                    col_cnt_d = wrap ? '0 : cnt_inc;
                    if (full) begin
                        out_valid_d = 1'b1;
                        pixel_d     = filt;
                        out_last_d  = bus.in_last;
                    end
                    if (bus.in_last) begin
                        state_d = ST_DONE;
                        if (!full) done_d = 1'b1;
                    end else if (wrap) begin
                        state_d = ST_FILL;
                    end else if (full) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            pixel_q     <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            out_count_q <= '0;
            // NOTE: the window is only five columns wide, so clearing it on reset is cheap and keeps state deterministic.
            for (int i = 0; i < 5; i++) win_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            pixel_q     <= pixel_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            out_count_q <= out_count_d;
            if (accept) begin
                for (int i = 0; i < 5; i++) win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.pixel_out = pixel_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign done          = done_q;
    assign out_count     = out_count_q;
endmodule

// File: tb/tb_gaussian_filter_stream.sv
// Scoreboard bench for gaussian_filter_stream: two instances (STRIP_W=8 and STRIP_W=6)
// share the stimulus; sel chooses which one is observed.
module tb_gaussian_filter_stream;
    localparam int PW  = 5;
    localparam int CW5 = 5 * PW;
    localparam int K5 [5][5] = '{
        '{2, 4, 5, 4, 2}, '{4, 9, 12, 9, 4}, '{5, 12, 15, 12, 5},
        '{4, 9, 12, 9, 4}, '{2, 4, 5, 4, 2}
    };
    localparam int K3 [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

    typedef struct packed {
        logic          last;
        logic [PW-1:0] pix;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, mode, sel;
    logic in_valid, in_last, out_ready;
    logic [CW5-1:0] in_col;
    logic busy8, done8, busy6, done6;
    logic [15:0] cnt8, cnt6;

    logic o_in_ready, o_out_valid, o_last, o_busy, o_done;
    logic [PW-1:0] o_pix;
    logic [15:0] o_cnt;

    int total = 0;
    int bad   = 0;

    exp_t           sb [$];
    logic [PW-1:0]  got [$];
    logic [PW-1:0]  ref_seq [$];
    int             acc_out_idx [$];
    logic [CW5-1:0] stim [$];
    logic [CW5-1:0] mw [5];

    always #5 clk = ~clk;

    gaussian_filter_stream_if #(.PW(PW)) bus8 ();
    gaussian_filter_stream_if #(.PW(PW)) bus6 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_col    = in_col;
    assign bus8.in_last   = in_last;
    assign bus8.out_ready = out_ready;
    assign bus6.in_valid  = in_valid;
    assign bus6.in_col    = in_col;
    assign bus6.in_last   = in_last;
    assign bus6.out_ready = out_ready;

    gaussian_filter_stream #(.PW(PW), .STRIP_W(8), .CNT_W(16)) dut8 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .bus(bus8.slave),
        .busy(busy8), .done(done8), .out_count(cnt8)
    );
    gaussian_filter_stream #(.PW(PW), .STRIP_W(6), .CNT_W(16)) dut6 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .bus(bus6.slave),
        .busy(busy6), .done(done6), .out_count(cnt6)
    );

    assign o_in_ready  = sel ? bus6.in_ready  : bus8.in_ready;
    assign o_out_valid = sel ? bus6.out_valid : bus8.out_valid;
    assign o_pix       = sel ? bus6.pixel_out : bus8.pixel_out;
    assign o_last      = sel ? bus6.out_last  : bus8.out_last;
    assign o_busy      = sel ? busy6 : busy8;
    assign o_done      = sel ? done6 : done8;
    assign o_cnt       = sel ? cnt6  : cnt8;

    // Reference smoother on the bench's own copy of the window (mw[0] oldest column).
    function automatic logic [PW-1:0] model_pix(input logic m);
        int acc;
        int res;
        logic [CW5-1:0] colv;
        acc = 0;
        if (!m) begin
            for (int c = 0; c < 5; c++) begin
                colv = mw[c];
                for (int r = 0; r < 5; r++) acc += K5[r][c] * int'(colv[r*PW +: PW]);
            end
            res = (acc * 103 + 8192) >> 14;
        end else begin
            for (int c = 1; c < 4; c++) begin
                colv = mw[c];
                for (int r = 1; r < 4; r++) acc += K3[r-1][c-1] * int'(colv[r*PW +: PW]);
            end
            res = (acc + 8) >> 4;
        end
        if (res > (1 << PW) - 1) res = (1 << PW) - 1;
        return res[PW-1:0];
    endfunction

    function automatic logic [CW5-1:0] flat_col(input int v);
        logic [PW-1:0] p;
        p = v[PW-1:0];
        return {5{p}};
    endfunction

    task automatic run_frame(input logic m, input int sw, input bit rnd, input int stall_len);
        int   n, idx, mcnt, cyc, stall_cnt, nout;
        bit   stalled_once, stalling, done_exp, done_seen, push_chk;
        logic [PW-1:0] held;
        exp_t e;
        n = stim.size();
        idx = 0; mcnt = 0; cyc = 0; stall_cnt = 0; nout = 0;
        stalled_once = 0; done_exp = 0; done_seen = 0; push_chk = 0; held = '0;
        sb.delete(); got.delete(); acc_out_idx.delete();
        for (int i = 0; i < 5; i++) mw[i] = '0;

        in_valid = 0; in_last = 0; out_ready = 1;
        start = 1; mode = m;
        @(posedge clk); #1;
        start = 0; mode = ~m;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b1 || o_cnt !== 16'd0) begin
            bad++;
            $display("FAIL start_state: busy=%0b count=%0d want busy=1 count=0", o_busy, o_cnt);
        end

        while (!(idx == n && sb.size() == 0 && done_seen) && cyc < 400) begin
            @(posedge clk); #1;
            if (stall_len > 0 && !stalled_once && o_out_valid) begin
                stall_cnt = stall_len;
                stalled_once = 1;
                held = o_pix;
            end
            stalling = stall_cnt > 0;
            if (stalling) begin
                out_ready = 0;
                stall_cnt--;
            end else begin
                out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            in_valid = (idx < n) && (!rnd || $urandom_range(3, 0) != 0);
            if (in_valid) in_col = stim[idx];
            else          in_col = CW5'($urandom);
            in_last = in_valid && (idx == n - 1);

            @(negedge clk);
            cyc++;
            total++;
            if (o_done !== done_exp) begin
                bad++;
                $display("FAIL done_pulse: got=%0b want=%0b (cycle %0d)", o_done, done_exp, cyc);
            end
            if (o_done) done_seen = 1;
            done_exp = 0;
            if (push_chk) begin
                total++;
                if (o_out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL latency: out_valid=%0b want=1 one cycle after window-full accept", o_out_valid);
                end
                push_chk = 0;
            end
            if (stalling) begin
                total++;
                if (o_in_ready !== 1'b0 || o_pix !== held) begin
                    bad++;
                    $display("FAIL stall_hold: in_ready=%0b pix=%0d want in_ready=0 pix=%0d", o_in_ready, o_pix, held);
                end
            end
            if (o_out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out: pix=%0d want no output", o_pix);
                end else begin
                    e = sb.pop_front();
                    if (o_pix !== e.pix || o_last !== e.last) begin
                        bad++;
                        $display("FAIL pixel: got pix=%0d last=%0b want pix=%0d last=%0b", o_pix, o_last, e.pix, e.last);
                    end
                    got.push_back(o_pix);
                    nout++;
                    if (e.last) done_exp = 1;
                end
            end
            if (in_valid && o_in_ready) begin
                for (int i = 0; i < 4; i++) mw[i] = mw[i+1];
                mw[4] = in_col;
                mcnt++;
                if (mcnt >= 5) begin
                    e.pix  = model_pix(m);
                    e.last = in_last;
                    sb.push_back(e);
                    acc_out_idx.push_back(idx + 1);
                    push_chk = 1;
                end else if (in_last) begin
                    done_exp = 1;
                end
                if (mcnt == sw) mcnt = 0;
                idx++;
            end
        end
        if (cyc >= 400) begin
            total++; bad++;
            $display("FAIL timeout: accepted=%0d of %0d pending=%0d done_seen=%0b", idx, n, sb.size(), done_seen);
        end
        total++;
        if (o_cnt !== 16'(nout) || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: count=%0d busy=%0b want count=%0d busy=0", o_cnt, o_busy, nout);
        end
    endtask

    task automatic expect_all(input string name, input int n, input int v);
        total++;
        if (got.size() != n) begin
            bad++;
            $display("FAIL %s_count: got=%0d want=%0d", name, got.size(), n);
        end
        foreach (got[i]) begin
            total++;
            if (got[i] !== PW'(v)) begin
                bad++;
                $display("FAIL %s[%0d]: got=%0d want=%0d", name, i, got[i], v);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_out_valid, o_last, o_done, o_in_ready, o_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got=%b want=00000", {o_out_valid, o_last, o_done, o_in_ready, o_busy});
        end
        total++;
        if (o_pix !== '0 || o_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_data: pix=%0d count=%0d want 0 0", o_pix, o_cnt);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_constant_5x5();
        sel = 0;
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(flat_col(10));
        run_frame(1'b0, 8, 0, 0);
        expect_all("const10_5x5", 4, 10);
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(flat_col(31));
        run_frame(1'b0, 8, 0, 0);
        expect_all("const31_5x5", 4, 31);
    endtask

    task automatic test_impulse();
        logic [CW5-1:0] col;
        sel = 0;
        col = '0;
        col[2*PW +: PW] = PW'(31);
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(i == 3 ? col : '0);
        run_frame(1'b0, 8, 0, 0);
        total++;
        if (got.size() != 4 || got[1] !== PW'(3)) begin
            bad++;
            $display("FAIL impulse_5x5_centre: got=%0d want=3", got.size() > 1 ? got[1] : 'x);
        end
        col[2*PW +: PW] = PW'(16);
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(i == 3 ? col : '0);
        run_frame(1'b1, 8, 0, 0);
        total++;
        if (got.size() != 4 || got[0] !== PW'(2) || got[1] !== PW'(4) || got[2] !== PW'(2)) begin
            bad++;
            $display("FAIL impulse_3x3: got=%0d,%0d,%0d want=2,4,2",
                     got.size() > 0 ? got[0] : 'x, got.size() > 1 ? got[1] : 'x, got.size() > 2 ? got[2] : 'x);
        end
    endtask

    task automatic test_mode_3x3();
        sel = 0;
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(flat_col(10));
        run_frame(1'b1, 8, 0, 0);
        expect_all("const10_3x3", 4, 10);
    endtask

    task automatic test_backpressure();
        sel = 0;
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(CW5'($urandom));
        run_frame(1'b0, 8, 0, 0);
        ref_seq = got;
        run_frame(1'b0, 8, 0, 5);
        total++;
        if (got.size() != ref_seq.size()) begin
            bad++;
            $display("FAIL stall_seq_len: got=%0d want=%0d", got.size(), ref_seq.size());
        end else begin
            foreach (got[i]) begin
                total++;
                if (got[i] !== ref_seq[i]) begin
                    bad++;
                    $display("FAIL stall_seq[%0d]: got=%0d want=%0d", i, got[i], ref_seq[i]);
                end
            end
        end
    endtask

    task automatic test_strip_wrap();
        sel = 1;
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(CW5'($urandom));
        run_frame(1'b0, 6, 0, 0);
        total++;
        if (got.size() != 4 || acc_out_idx.size() != 4 || acc_out_idx[0] != 5 || acc_out_idx[1] != 6 ||
            acc_out_idx[2] != 11 || acc_out_idx[3] != 12) begin
            bad++;
            $display("FAIL strip_outputs: got=%0d outputs want=4 after accepts 5,6,11,12", got.size());
        end
        sel = 0;
    endtask

    task automatic test_last_without_output();
        sel = 0;
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(CW5'($urandom));
        run_frame(1'b0, 8, 0, 0);
        total++;
        if (got.size() != 0) begin
            bad++;
            $display("FAIL short_frame: got=%0d outputs want=0", got.size());
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        for (int f = 0; f < 2; f++) begin
            stim.delete();
            for (int i = 0; i < 16; i++) stim.push_back(CW5'($urandom));
            run_frame(f[0], 8, 1, 0);
            total++;
            if (got.size() != 8) begin
                bad++;
                $display("FAIL b2b_count[%0d]: got=%0d want=8", f, got.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int cyc;
        sel = 0;
        start = 1; mode = 0; in_valid = 0; in_last = 0; out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1;
        in_col = flat_col(10);
        acc = 0; cyc = 0;
        while (acc < 6 && cyc < 50) begin
            @(negedge clk);
            if (o_in_ready) acc++;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        total++;
        if (acc != 6 || o_out_valid !== 1'b1 || o_cnt !== 16'd1) begin
            bad++;
            $display("FAIL pre_reset: accepts=%0d out_valid=%0b count=%0d want 6 1 1", acc, o_out_valid, o_cnt);
        end
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        total++;
        if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_cnt !== 16'd0 || o_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: out_valid=%0b busy=%0b count=%0d in_ready=%0b want 0 0 0 0",
                     o_out_valid, o_busy, o_cnt, o_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (o_done !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_done: got=%0b want=0", o_done);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(flat_col(10));
        run_frame(1'b0, 8, 0, 0);
        expect_all("after_reset", 4, 10);
    endtask

    initial begin
        reset = 1; start = 0; mode = 0; sel = 0;
        in_valid = 0; in_col = '0; in_last = 0; out_ready = 0;
        test_reset();
        test_constant_5x5();
        test_impulse();
        test_mode_3x3();
        test_backpressure();
        test_strip_wrap();
        test_last_without_output();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
